// File: rtl/alu_div_seq.sv
// Sequential restoring divider for RV32M DIV/DIVU/REM/REMU.
// Borrows the shared 32-bit adder for every negate and subtract step; fixed 35-cycle latency.
module alu_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [1:0]      iOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic [XLEN-1:0] oAddX,
  output logic [XLEN-1:0] oAddY,
  output logic            oAddCarry,
  input  logic [XLEN-1:0] iAddS,
  input  logic            iAddCarry
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NEGA = 3'd1,
    NEGB = 3'd2,
    DIV  = 3'd3,
    FIX  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   q_q, q_d;
  logic [XLEN-1:0]   r_q, r_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic              is_signed;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   sel;
  logic              neg;

  assign is_signed = ~op_q[0];
  assign shifted   = {r_q[XLEN-2:0], q_q[XLEN-1]};
  assign sel       = op_q[1] ? r_q : q_q;

  always_comb begin
    unique case (op_q)
      2'b00:   neg = negq_q;
      2'b10:   neg = negr_q;
      default: neg = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    q_d       = q_q;
    r_d       = r_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    oAddX     = '0;
    oAddY     = '0;
    oAddCarry = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          a_d     = iA;
          b_d     = iB;
          op_d    = iOp;
          state_d = NEGA;
        end
      end
      NEGA: begin
        oAddX     = ~a_q;
        oAddCarry = 1'b1;
        if (is_signed && a_q[XLEN-1]) a_d = iAddS;
        negq_d  = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]) & (b_q != '0);
        negr_d  = is_signed & a_q[XLEN-1];
        state_d = NEGB;
      end
      NEGB: begin
        oAddX     = ~b_q;
        oAddCarry = 1'b1;
        if (is_signed && b_q[XLEN-1]) b_d = iAddS;
        q_d     = a_q;
        r_d     = '0;
        cnt_d   = 5'd31;
        state_d = DIV;
      end
      DIV: begin
        oAddX     = shifted;
        oAddY     = ~b_q;
        oAddCarry = 1'b1;
        // R[31] set means the 33-bit partial remainder already exceeds any divisor.
        if (iAddCarry || r_q[XLEN-1]) begin
          r_d = iAddS;
          q_d = {q_q[XLEN-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FIX;
      end
      FIX: begin
        oAddX     = ~sel;
        oAddCarry = 1'b1;
        res_d     = neg ? iAddS : sel;
        state_d   = DONE;
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (iFlush) state_d = IDLE;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign oReady  = (state_q == IDLE);
  assign oValid  = (state_q == DONE);
  assign oResult = res_q;

endmodule
